// File: rtl/wb_pkg.sv
// ============================================================================
// wb_pkg : shared types and constants for the write-back scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int WB_DW = 16;
  localparam int WB_AW = 3;

  localparam logic [WB_AW-1:0] PC_ADDR = 3'd3;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic [WB_DW-1:0] flags;
    logic             wf;
  } wb_beat_t;

endpackage

`default_nettype wire

// File: rtl/wb_hold.sv
// ============================================================================
// wb_hold : one-entry buffer parking a memory beat that lost arbitration
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_hold
  import wb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load_i,
  input  logic     drain_i,
  input  wb_beat_t beat_i,
  output logic     full_o,
  output wb_beat_t beat_o
);

  logic     full_q, full_d;
  wb_beat_t beat_q, beat_d;

  // Load only happens while empty and drain only while full, so they never overlap.
  always_comb begin
    full_d = full_q;
    beat_d = beat_q;
    if (load_i) begin
      full_d = 1'b1;
      beat_d = beat_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      beat_q <= '0;
    end else begin
      full_q <= full_d;
      beat_q <= beat_d;
    end
  end

  assign full_o = full_q;
  assign beat_o = beat_q;

endmodule

`default_nettype wire

// File: rtl/wb_sched.sv
// ============================================================================
// wb_sched : register scoreboard and ALU/memory write-back arbiter feeding
//            the single register-file write port
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_sched
  import wb_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [AW-1:0] iss_a_addr,
  input  logic [AW-1:0] iss_b_addr,
  input  logic [AW-1:0] iss_dest_addr,
  input  logic          iss_dest_wr,
  input  logic          alu_wb_valid,
  input  logic [AW-1:0] alu_wb_addr,
  input  logic [DW-1:0] alu_wb_data,
  input  logic [DW-1:0] alu_wb_flags,
  input  logic          alu_wb_wf,
  input  logic          mem_wb_valid,
  output logic          mem_wb_ready,
  input  logic [AW-1:0] mem_wb_addr,
  input  logic [DW-1:0] mem_wb_data,
  input  logic [DW-1:0] mem_wb_flags,
  input  logic          mem_wb_wf,
  output logic          dest_r_wr,
  output logic [AW-1:0] dest_r_addr,
  output logic [DW-1:0] alu_r,
  output logic          dest_w_flags,
  output logic [DW-1:0] alu_flags
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] w_clr, w_set, w_busy;
  logic            dest_r_wr_q, dest_r_wr_d;
  logic [AW-1:0]   dest_r_addr_q, dest_r_addr_d;
  logic [DW-1:0]   alu_r_q, alu_r_d;
  logic            dest_w_flags_q, dest_w_flags_d;
  logic [DW-1:0]   alu_flags_q, alu_flags_d;

  wb_beat_t w_alu_beat, w_mem_beat, w_hold_beat, w_win_beat;
  logic     w_hold_full, w_mem_acc, w_hold_load, w_hold_drain;
  logic     w_win, w_src;

  // Scoreboard: a bit being written back this cycle is free thanks to the RF bypass.
  assign w_clr  = dest_r_wr_q ? (pending_q & (NREG'(1) << dest_r_addr_q)) : '0;
  assign w_busy = pending_q & ~w_clr;

  assign iss_ready = ~rst & ~w_hold_full
                   & ~w_busy[iss_a_addr] & ~w_busy[iss_b_addr]
                   & ~(iss_dest_wr & w_busy[iss_dest_addr]);

  assign w_set = (iss_valid & iss_ready & iss_dest_wr && iss_dest_addr != PC_ADDR)
               ? (NREG'(1) << iss_dest_addr) : '0;

  // Set is OR'ed in after the clear so a same-cycle collision keeps the bit.
  assign pending_d = (pending_q & ~w_clr) | w_set;

  assign mem_wb_ready = ~w_hold_full;
  assign w_mem_acc    = mem_wb_valid & ~w_hold_full;
  assign w_hold_load  = alu_wb_valid & w_mem_acc;
  assign w_hold_drain = ~alu_wb_valid & w_hold_full;

  assign w_alu_beat = '{addr: alu_wb_addr, data: alu_wb_data, flags: alu_wb_flags, wf: alu_wb_wf};
  assign w_mem_beat = '{addr: mem_wb_addr, data: mem_wb_data, flags: mem_wb_flags, wf: mem_wb_wf};

  wb_hold u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_hold_load),
    .drain_i (w_hold_drain),
    .beat_i  (w_mem_beat),
    .full_o  (w_hold_full),
    .beat_o  (w_hold_beat)
  );

  // ALU always wins; on the memory side a parked beat goes ahead of a fresh one.
  assign w_src      = alu_wb_valid ? SRC_ALU : SRC_MEM;
  assign w_win      = alu_wb_valid | w_hold_full | w_mem_acc;
  assign w_win_beat = (w_src == SRC_ALU) ? w_alu_beat
                    : (w_hold_full ? w_hold_beat : w_mem_beat);

  always_comb begin
    dest_r_wr_d    = w_win;
    dest_w_flags_d = w_win & w_win_beat.wf;
    dest_r_addr_d  = dest_r_addr_q;
    alu_r_d        = alu_r_q;
    alu_flags_d    = alu_flags_q;
    if (w_win) begin
      dest_r_addr_d = w_win_beat.addr;
      alu_r_d       = w_win_beat.data;
      alu_flags_d   = w_win_beat.flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q      <= '0;
      dest_r_wr_q    <= 1'b0;
      dest_r_addr_q  <= '0;
      alu_r_q        <= '0;
      dest_w_flags_q <= 1'b0;
      alu_flags_q    <= '0;
    end else begin
      pending_q      <= pending_d;
      dest_r_wr_q    <= dest_r_wr_d;
      dest_r_addr_q  <= dest_r_addr_d;
      alu_r_q        <= alu_r_d;
      dest_w_flags_q <= dest_w_flags_d;
      alu_flags_q    <= alu_flags_d;
    end
  end

  assign dest_r_wr    = dest_r_wr_q;
  assign dest_r_addr  = dest_r_addr_q;
  assign alu_r        = alu_r_q;
  assign dest_w_flags = dest_w_flags_q;
  assign alu_flags    = alu_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_sched.sv
// ============================================================================
// tb_wb_sched : directed self-checking bench for wb_sched
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid, iss_ready, iss_dest_wr;
  logic [2:0]  iss_a_addr, iss_b_addr, iss_dest_addr;
  logic        alu_wb_valid, alu_wb_wf;
  logic [2:0]  alu_wb_addr;
  logic [15:0] alu_wb_data, alu_wb_flags;
  logic        mem_wb_valid, mem_wb_ready, mem_wb_wf;
  logic [2:0]  mem_wb_addr;
  logic [15:0] mem_wb_data, mem_wb_flags;
  logic        dest_r_wr, dest_w_flags;
  logic [2:0]  dest_r_addr;
  logic [15:0] alu_r, alu_flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_sched #(.DW(16), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_a_addr(iss_a_addr), .iss_b_addr(iss_b_addr),
    .iss_dest_addr(iss_dest_addr), .iss_dest_wr(iss_dest_wr),
    .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr),
    .alu_wb_data(alu_wb_data), .alu_wb_flags(alu_wb_flags), .alu_wb_wf(alu_wb_wf),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
    .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
    .mem_wb_flags(mem_wb_flags), .mem_wb_wf(mem_wb_wf),
    .dest_r_wr(dest_r_wr), .dest_r_addr(dest_r_addr), .alu_r(alu_r),
    .dest_w_flags(dest_w_flags), .alu_flags(alu_flags)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    iss_valid = 0; iss_a_addr = 0; iss_b_addr = 0; iss_dest_addr = 0; iss_dest_wr = 0;
    alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0; alu_wb_flags = 0; alu_wb_wf = 0;
    mem_wb_valid = 0; mem_wb_addr = 0; mem_wb_data = 0; mem_wb_flags = 0; mem_wb_wf = 0;
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d, input logic wr);
    iss_valid = 1; iss_a_addr = a; iss_b_addr = b; iss_dest_addr = d; iss_dest_wr = wr;
  endtask

  task automatic alu(input logic [2:0] ad, input logic [15:0] da, input logic [15:0] fl, input logic wf);
    alu_wb_valid = 1; alu_wb_addr = ad; alu_wb_data = da; alu_wb_flags = fl; alu_wb_wf = wf;
  endtask

  task automatic mem(input logic [2:0] ad, input logic [15:0] da, input logic [15:0] fl, input logic wf);
    mem_wb_valid = 1; mem_wb_addr = ad; mem_wb_data = da; mem_wb_flags = fl; mem_wb_wf = wf;
  endtask

  task automatic test_reset;
    idle();
    issue(3'd1, 3'd2, 3'd4, 1'b1);
    step(); step();
    checks++; if (dest_r_wr !== 1'b0) begin failures++; $display("FAIL rst_wr got=%0b exp=0", dest_r_wr); end
    checks++; if (dest_r_addr !== 3'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", dest_r_addr); end
    checks++; if (alu_r !== 16'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", alu_r); end
    checks++; if (dest_w_flags !== 1'b0 || alu_flags !== 16'h0) begin failures++; $display("FAIL rst_flags got=%0b/%h exp=0/0", dest_w_flags, alu_flags); end
    checks++; if (mem_wb_ready !== 1'b1) begin failures++; $display("FAIL rst_mem_ready got=%0b exp=1", mem_wb_ready); end
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL rst_iss_ready got=%0b exp=0", iss_ready); end
    @(negedge clk); rst = 0; #1;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL first_issue_ready got=%0b exp=1", iss_ready); end
    step();
    checks++; if (dut.pending_q !== 8'h10) begin failures++; $display("FAIL first_issue_pending got=%h exp=10", dut.pending_q); end
    idle();
  endtask

  task automatic test_raw;
    issue(3'd4, 3'd0, 3'd0, 1'b0); #1;
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL raw_stall got=%0b exp=0", iss_ready); end
    alu(3'd4, 16'hBEEF, 16'h0001, 1'b1); #1;
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL raw_stall_wb_cycle got=%0b exp=0", iss_ready); end
    step();
    alu_wb_valid = 0; #1;
    checks++; if (dest_r_wr !== 1'b1 || dest_r_addr !== 3'd4 || alu_r !== 16'hBEEF) begin failures++; $display("FAIL raw_wb got=%0b/%0d/%h exp=1/4/beef", dest_r_wr, dest_r_addr, alu_r); end
    checks++; if (dest_w_flags !== 1'b1 || alu_flags !== 16'h0001) begin failures++; $display("FAIL raw_flags got=%0b/%h exp=1/0001", dest_w_flags, alu_flags); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL raw_bypass_issue got=%0b exp=1", iss_ready); end
    step();
    idle(); #1;
    checks++; if (dut.pending_q !== 8'h00 || dest_r_wr !== 1'b0) begin failures++; $display("FAIL raw_after got=%h/%0b exp=00/0", dut.pending_q, dest_r_wr); end
  endtask

  task automatic test_waw;
    issue(3'd3, 3'd3, 3'd5, 1'b1);
    step();
    issue(3'd0, 3'd0, 3'd5, 1'b1); #1;
    checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL waw_stall got=%0b exp=0", iss_ready); end
    alu(3'd5, 16'h1234, 16'h0, 1'b0);
    step();
    alu_wb_valid = 0; #1;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL waw_release got=%0b exp=1", iss_ready); end
    step();
    iss_valid = 0; #1;
    checks++; if (dut.pending_q !== 8'h20) begin failures++; $display("FAIL set_wins got=%h exp=20", dut.pending_q); end
    alu(3'd5, 16'h5678, 16'h0, 1'b0);
    step(); idle(); step();
    checks++; if (dut.pending_q !== 8'h00) begin failures++; $display("FAIL waw_clear got=%h exp=00", dut.pending_q); end
  endtask

  task automatic test_collision;
    alu(3'd1, 16'h0011, 16'h0000, 1'b0);
    mem(3'd5, 16'h0055, 16'h00AA, 1'b1); #1;
    checks++; if (mem_wb_ready !== 1'b1) begin failures++; $display("FAIL coll_mem_ready_n got=%0b exp=1", mem_wb_ready); end
    step();
    idle(); #1;
    checks++; if (dest_r_wr !== 1'b1 || dest_r_addr !== 3'd1 || alu_r !== 16'h0011 || dest_w_flags !== 1'b0) begin failures++; $display("FAIL coll_alu got=%0b/%0d/%h/%0b exp=1/1/0011/0", dest_r_wr, dest_r_addr, alu_r, dest_w_flags); end
    checks++; if (mem_wb_ready !== 1'b0) begin failures++; $display("FAIL coll_mem_ready_n1 got=%0b exp=0", mem_wb_ready); end
    step();
    checks++; if (dest_r_wr !== 1'b1 || dest_r_addr !== 3'd5 || alu_r !== 16'h0055) begin failures++; $display("FAIL coll_mem got=%0b/%0d/%h exp=1/5/0055", dest_r_wr, dest_r_addr, alu_r); end
    checks++; if (dest_w_flags !== 1'b1 || alu_flags !== 16'h00AA) begin failures++; $display("FAIL coll_mem_flags got=%0b/%h exp=1/00aa", dest_w_flags, alu_flags); end
    checks++; if (mem_wb_ready !== 1'b1) begin failures++; $display("FAIL coll_mem_ready_n2 got=%0b exp=1", mem_wb_ready); end
    step();
    checks++; if (dest_r_wr !== 1'b0) begin failures++; $display("FAIL coll_idle got=%0b exp=0", dest_r_wr); end
  endtask

  task automatic test_hold_starve;
    logic [15:0] exp_d;
    alu(3'd1, 16'h0A01, 16'h0, 1'b0);
    mem(3'd6, 16'h0B06, 16'h0, 1'b0);
    step();
    mem_wb_valid = 0;
    for (int k = 0; k < 3; k++) begin
      alu(3'(2 + k), 16'h0A02 + 16'(k), 16'h0, 1'b0);
      issue(3'd0, 3'd0, 3'd0, 1'b0); #1;
      exp_d = 16'h0A01 + 16'(k);
      checks++; if (iss_ready !== 1'b0) begin failures++; $display("FAIL starve_iss_ready k=%0d got=%0b exp=0", k, iss_ready); end
      checks++; if (dest_r_wr !== 1'b1 || dest_r_addr !== 3'(1 + k) || alu_r !== exp_d) begin failures++; $display("FAIL starve_alu k=%0d got=%0d/%h exp=%0d/%h", k, dest_r_addr, alu_r, 1 + k, exp_d); end
      step();
    end
    alu_wb_valid = 0; #1;
    checks++; if (dest_r_addr !== 3'd4 || alu_r !== 16'h0A04 || iss_ready !== 1'b0) begin failures++; $display("FAIL starve_last_alu got=%0d/%h/%0b exp=4/0a04/0", dest_r_addr, alu_r, iss_ready); end
    step();
    checks++; if (dest_r_wr !== 1'b1 || dest_r_addr !== 3'd6 || alu_r !== 16'h0B06) begin failures++; $display("FAIL starve_held got=%0b/%0d/%h exp=1/6/0b06", dest_r_wr, dest_r_addr, alu_r); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL starve_release got=%0b exp=1", iss_ready); end
    idle(); step();
    checks++; if (dest_r_wr !== 1'b0) begin failures++; $display("FAIL starve_idle got=%0b exp=0", dest_r_wr); end
  endtask

  task automatic test_pc;
    issue(3'd3, 3'd3, 3'd3, 1'b1); #1;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL pc_dest_ready got=%0b exp=1", iss_ready); end
    step();
    checks++; if (dut.pending_q !== 8'h00) begin failures++; $display("FAIL pc_pending got=%h exp=00", dut.pending_q); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL pc_read_ready got=%0b exp=1", iss_ready); end
    idle(); step();
  endtask

  task automatic test_reset_mid;
    logic [2:0] dl [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    for (int i = 0; i < 6; i++) begin
      issue(3'd3, 3'd3, dl[i], 1'b1);
      step();
    end
    issue(3'd3, 3'd3, 3'd7, 1'b1);
    alu(3'd0, 16'hC000, 16'h0, 1'b0);
    mem(3'd1, 16'hC001, 16'h0, 1'b0);
    step();
    idle(); #1;
    checks++; if (dut.pending_q !== 8'hF7 || mem_wb_ready !== 1'b0) begin failures++; $display("FAIL mid_setup got=%h/%0b exp=f7/0", dut.pending_q, mem_wb_ready); end
    #1 rst = 1; #1;
    checks++; if (dut.pending_q !== 8'h00 || dest_r_wr !== 1'b0) begin failures++; $display("FAIL mid_async got=%h/%0b exp=00/0", dut.pending_q, dest_r_wr); end
    checks++; if (mem_wb_ready !== 1'b1 || alu_r !== 16'h0 || iss_ready !== 1'b0) begin failures++; $display("FAIL mid_async_outs got=%0b/%h/%0b exp=1/0000/0", mem_wb_ready, alu_r, iss_ready); end
    @(negedge clk); rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (dest_r_wr !== 1'b0) begin failures++; $display("FAIL mid_no_wb c=%0d got=%0b exp=0", i, dest_r_wr); end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_collision();
    test_hold_starve();
    test_pc();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
